// File: rtl/unpack_adder_process_pkg.sv
// Shared constants and types for the floating-point adder unpack stage.
package unpack_adder_process_pkg;

   localparam logic [3:0] sin_cos     = 4'd0;
   localparam logic [3:0] sinh_cosh   = 4'd1;
   localparam logic [3:0] arctan      = 4'd2;
   localparam logic [3:0] arctanh     = 4'd3;
   localparam logic [3:0] exponential = 4'd4;
   localparam logic [3:0] sqr_root    = 4'd5;
   localparam logic [3:0] division    = 4'd6;
   localparam logic [3:0] tangent     = 4'd7;
   localparam logic [3:0] tanh_op     = 4'd8;
   localparam logic [3:0] nat_log     = 4'd9;
   localparam logic [3:0] hypotenuse  = 4'd10;
   localparam logic [3:0] PreProcess  = 4'd11;

   localparam logic no_idle  = 1'b0;
   localparam logic put_idle = 1'b1;

   localparam logic [7:0]  EXP_BIAS   = 8'd127;
   localparam logic [7:0]  DENORM_EXP = 8'h82;  // -126
   localparam logic [31:0] QNAN       = 32'h7FC0_0000;
   localparam int          MANT_W     = 27;

   typedef struct packed {
      logic              sign;
      logic [7:0]        exponent;
      logic [MANT_W-1:0] mantissa;
   } fp_fields_t;

   typedef struct packed {
      logic nan;
      logic inf;
      logic zero;
      logic denorm;
   } fp_class_t;

   // Any word with a zero exponent field collapses to a signed zero.
   function automatic logic [31:0] flush_denorm(input logic [31:0] value);
      logic [31:0] result;
      if (value[30:23] == 8'd0) begin
         result = {value[31], 31'd0};
      end else begin
         result = value;
      end
      return result;
   endfunction

endpackage

// File: rtl/unpack_adder_process_split.sv
// Combinational split of one IEEE single into sign, unbiased exponent,
// extended mantissa and special-value flags.
module float_field_split
   import unpack_adder_process_pkg::*;
(
   input  logic [31:0]       value,
   output logic              sign,
   output logic [7:0]        exponent,
   output logic [MANT_W-1:0] mantissa,
   output logic              is_nan,
   output logic              is_inf,
   output logic              is_zero,
   output logic              is_denorm
);

   logic [7:0]  exp_field_s;
   logic [22:0] frac_s;
   logic        exp_ones_s;
   logic        exp_zero_s;
   logic        frac_zero_s;

   assign exp_field_s = value[30:23];
   assign frac_s      = value[22:0];
   assign exp_ones_s  = (exp_field_s == 8'hFF);
   assign exp_zero_s  = (exp_field_s == 8'h00);
   assign frac_zero_s = (frac_s == 23'd0);

   // Field decode; a zero exponent field takes the denormal scale with no hidden bit.
   always_comb begin
      sign      = value[31];
      is_nan    = exp_ones_s & ~frac_zero_s;
      is_inf    = exp_ones_s & frac_zero_s;
      is_zero   = exp_zero_s & frac_zero_s;
      is_denorm = exp_zero_s & ~frac_zero_s;
      if (exp_zero_s) begin
         exponent = DENORM_EXP;
         mantissa = {1'b0, frac_s, 3'b000};
      end else begin
         exponent = exp_field_s - EXP_BIAS;
         mantissa = {1'b1, frac_s, 3'b000};
      end
   end

endmodule

// File: rtl/unpack_adder_process.sv
// Two-stage unpack front end of the floating-point adder.
// Build option: define UNPACK_FTZ_EN to flush denormal operands to signed zero.
module unpack_adder_process
   import unpack_adder_process_pkg::*;
(
   input  logic              clock,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [31:0]       a_in,
   input  logic [31:0]       b_in,
   input  logic [31:0]       z_in,
   input  logic [3:0]        Opcode_in,
   input  logic [7:0]        InsTag_in,
   output logic              valid_Unpack,
   output logic              idle_Unpack,
   output logic [31:0]       sout_Unpack,
   output logic              a_sign,
   output logic              b_sign,
   output logic [7:0]        a_exponent,
   output logic [7:0]        b_exponent,
   output logic [MANT_W-1:0] a_mantissa,
   output logic [MANT_W-1:0] b_mantissa,
   output logic [31:0]       z_postUnpack,
   output logic [3:0]        Opcode_Unpack,
   output logic [7:0]        InsTagUnpack
);

   logic [31:0] a_word_s, b_word_s;
   fp_fields_t  a_fields_s, b_fields_s;
   fp_class_t   a_cls_s, b_cls_s;

`ifdef UNPACK_FTZ_EN
   assign a_word_s = flush_denorm(a_in);
   assign b_word_s = flush_denorm(b_in);
`else
   assign a_word_s = a_in;
   assign b_word_s = b_in;
`endif

   float_field_split u_split_a (
      .value     (a_word_s),
      .sign      (a_fields_s.sign),
      .exponent  (a_fields_s.exponent),
      .mantissa  (a_fields_s.mantissa),
      .is_nan    (a_cls_s.nan),
      .is_inf    (a_cls_s.inf),
      .is_zero   (a_cls_s.zero),
      .is_denorm (a_cls_s.denorm)
   );

   float_field_split u_split_b (
      .value     (b_word_s),
      .sign      (b_fields_s.sign),
      .exponent  (b_fields_s.exponent),
      .mantissa  (b_fields_s.mantissa),
      .is_nan    (b_cls_s.nan),
      .is_inf    (b_cls_s.inf),
      .is_zero   (b_cls_s.zero),
      .is_denorm (b_cls_s.denorm)
   );

   logic        v1_r;
   logic [31:0] a_r, b_r, z_r;
   logic [3:0]  op_r;
   logic [7:0]  tag_r;
   fp_fields_t  a_fields_r, b_fields_r;
   fp_class_t   a_cls_r, b_cls_r;

   // Stage 1: capture operands, side-band and per-operand decode.
   always_ff @(posedge clock) begin
      if (reset) begin
         v1_r       <= 1'b0;
         a_r        <= 32'd0;
         b_r        <= 32'd0;
         z_r        <= 32'd0;
         op_r       <= 4'd0;
         tag_r      <= 8'd0;
         a_fields_r <= '0;
         b_fields_r <= '0;
         a_cls_r    <= '0;
         b_cls_r    <= '0;
      end else begin
         v1_r       <= valid_in;
         a_r        <= a_word_s;
         b_r        <= b_word_s;
         z_r        <= z_in;
         op_r       <= Opcode_in;
         tag_r      <= InsTag_in;
         a_fields_r <= a_fields_s;
         b_fields_r <= b_fields_s;
         a_cls_r    <= a_cls_s;
         b_cls_r    <= b_cls_s;
      end
   end

   // Denormal flag is only informative; classification keys off nan/inf/zero.
   logic unused_denorm_s;
   assign unused_denorm_s = a_cls_r.denorm ^ b_cls_r.denorm;

   logic        idle_s;
   logic [31:0] sout_s;

   // Stage 2 special-operand resolution, first match wins.
   always_comb begin
      idle_s = no_idle;
      sout_s = 32'd0;
      if (a_cls_r.nan || b_cls_r.nan) begin
         idle_s = put_idle;
         sout_s = QNAN;
      end else if (a_cls_r.inf && b_cls_r.inf && (a_fields_r.sign != b_fields_r.sign)) begin
         idle_s = put_idle;
         sout_s = QNAN;
      end else if (a_cls_r.inf) begin
         idle_s = put_idle;
         sout_s = a_r;
      end else if (b_cls_r.inf) begin
         idle_s = put_idle;
         sout_s = b_r;
      end else if (a_cls_r.zero && b_cls_r.zero) begin
         idle_s = put_idle;
         sout_s = {a_fields_r.sign & b_fields_r.sign, 31'd0};
      end else if (a_cls_r.zero) begin
         idle_s = put_idle;
         sout_s = b_r;
      end else if (b_cls_r.zero) begin
         idle_s = put_idle;
         sout_s = a_r;
      end else begin
         idle_s = no_idle;
         sout_s = 32'd0;
      end
   end

   // Stage 2 output register; data holds while no pair is in the stage.
   always_ff @(posedge clock) begin
      if (reset) begin
         valid_Unpack  <= 1'b0;
         idle_Unpack   <= put_idle;
         sout_Unpack   <= 32'd0;
         a_sign        <= 1'b0;
         b_sign        <= 1'b0;
         a_exponent    <= 8'd0;
         b_exponent    <= 8'd0;
         a_mantissa    <= '0;
         b_mantissa    <= '0;
         z_postUnpack  <= 32'd0;
         Opcode_Unpack <= 4'd0;
         InsTagUnpack  <= 8'd0;
      end else begin
         valid_Unpack <= v1_r;
         if (v1_r) begin
            idle_Unpack   <= idle_s;
            sout_Unpack   <= sout_s;
            a_sign        <= a_fields_r.sign;
            b_sign        <= b_fields_r.sign;
            a_exponent    <= a_fields_r.exponent;
            b_exponent    <= b_fields_r.exponent;
            a_mantissa    <= a_fields_r.mantissa;
            b_mantissa    <= b_fields_r.mantissa;
            z_postUnpack  <= z_r;
            Opcode_Unpack <= op_r;
            InsTagUnpack  <= tag_r;
         end
      end
   end

endmodule

// File: tb/tb_unpack_adder_process.sv
// Scoreboard bench for unpack_adder_process: directed pairs with hand-computed results.
module tb_unpack_adder_process;
   import unpack_adder_process_pkg::*;

   logic        clock = 1'b0;
   logic        reset;
   logic        valid_in;
   logic [31:0] a_in, b_in, z_in;
   logic [3:0]  Opcode_in;
   logic [7:0]  InsTag_in;
   logic        valid_Unpack, idle_Unpack, a_sign, b_sign;
   logic [31:0] sout_Unpack, z_postUnpack;
   logic [7:0]  a_exponent, b_exponent, InsTagUnpack;
   logic [26:0] a_mantissa, b_mantissa;
   logic [3:0]  Opcode_Unpack;

   unpack_adder_process dut (
      .clock(clock), .reset(reset), .valid_in(valid_in),
      .a_in(a_in), .b_in(b_in), .z_in(z_in),
      .Opcode_in(Opcode_in), .InsTag_in(InsTag_in),
      .valid_Unpack(valid_Unpack), .idle_Unpack(idle_Unpack), .sout_Unpack(sout_Unpack),
      .a_sign(a_sign), .b_sign(b_sign),
      .a_exponent(a_exponent), .b_exponent(b_exponent),
      .a_mantissa(a_mantissa), .b_mantissa(b_mantissa),
      .z_postUnpack(z_postUnpack), .Opcode_Unpack(Opcode_Unpack), .InsTagUnpack(InsTagUnpack)
   );

   always #5 clock = ~clock;

   typedef struct {
      int          cyc;
      logic        idle;
      logic [31:0] sout;
      logic        fields;
      logic        as, bs;
      logic [7:0]  ae, be;
      logic [26:0] am, bm;
      logic [31:0] z;
      logic [3:0]  op;
      logic [7:0]  tag;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every valid output is matched against the oldest expectation.
   always @(negedge clock) begin
      if (valid_Unpack === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: got tag 0x%0h expected no output", InsTagUnpack);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("latency", cyc, e.cyc + 2);
            chk("tag", {24'd0, InsTagUnpack}, {24'd0, e.tag});
            chk("opcode", {28'd0, Opcode_Unpack}, {28'd0, e.op});
            chk("z", z_postUnpack, e.z);
            chk("idle", {31'd0, idle_Unpack}, {31'd0, e.idle});
            chk("sout", sout_Unpack, e.sout);
            if (e.fields) begin
               chk("a_sign", {31'd0, a_sign}, {31'd0, e.as});
               chk("b_sign", {31'd0, b_sign}, {31'd0, e.bs});
               chk("a_exp", {24'd0, a_exponent}, {24'd0, e.ae});
               chk("b_exp", {24'd0, b_exponent}, {24'd0, e.be});
               chk("a_mant", {5'd0, a_mantissa}, {5'd0, e.am});
               chk("b_mant", {5'd0, b_mantissa}, {5'd0, e.bm});
            end
         end
      end
   end

   // Drive one pair after a rising edge and record what should come out.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                        input logic [7:0] tag, input logic idle, input logic [31:0] sout,
                        input logic fields, input logic as, input logic [7:0] ae,
                        input logic [26:0] am, input logic bs, input logic [7:0] be,
                        input logic [26:0] bm);
      exp_t e;
      @(posedge clock);
      #1;
      valid_in  = 1'b1;
      a_in      = a;
      b_in      = b;
      z_in      = {tag, tag, 16'hA5C3};
      Opcode_in = op;
      InsTag_in = tag;
      e.cyc = cyc; e.idle = idle; e.sout = sout; e.fields = fields;
      e.as = as; e.ae = ae; e.am = am; e.bs = bs; e.be = be; e.bm = bm;
      e.z = {tag, tag, 16'hA5C3}; e.op = op; e.tag = tag;
      q.push_back(e);
   endtask

   task automatic idle_cycle();
      @(posedge clock);
      #1;
      valid_in = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 20) begin
         @(posedge clock);
         n++;
      end
      chk("drain_queue_empty", q.size(), 32'd0);
   endtask

   task automatic check_reset_state();
      chk("rst_valid", {31'd0, valid_Unpack}, 32'd0);
      chk("rst_idle", {31'd0, idle_Unpack}, 32'd1);
      chk("rst_sout", sout_Unpack, 32'd0);
      chk("rst_tag", {24'd0, InsTagUnpack}, 32'd0);
      chk("rst_z", z_postUnpack, 32'd0);
      chk("rst_mant", {5'd0, a_mantissa | b_mantissa}, 32'd0);
      chk("rst_exp", {16'd0, a_exponent, b_exponent}, 32'd0);
      chk("rst_misc", {26'd0, Opcode_Unpack, a_sign, b_sign}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; valid_in = 1'b0; a_in = 32'd0; b_in = 32'd0;
      z_in = 32'd0; Opcode_in = 4'd0; InsTag_in = 8'd0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_state();
      @(posedge clock);
      #1;
      reset = 1'b0;

      // 1.5 and 2.0
      issue(32'h3FC0_0000, 32'h4000_0000, sin_cos, 8'h01, 1'b0, 32'd0,
            1'b1, 1'b0, 8'h00, 27'h600_0000, 1'b0, 8'h01, 27'h400_0000);
      // +Inf and -Inf
      issue(32'h7F80_0000, 32'hFF80_0000, division, 8'h02, 1'b1, 32'h7FC0_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      // -0 and +0
      issue(32'h8000_0000, 32'h0000_0000, sqr_root, 8'h03, 1'b1, 32'h0000_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
`ifdef UNPACK_FTZ_EN
      issue(32'h0000_0001, 32'h3F80_0000, arctan, 8'h04, 1'b1, 32'h3F80_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      issue(32'h3F80_0000, 32'h807F_FFFF, arctan, 8'h05, 1'b1, 32'h3F80_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
`else
      issue(32'h0000_0001, 32'h3F80_0000, arctan, 8'h04, 1'b0, 32'd0,
            1'b1, 1'b0, 8'h82, 27'h000_0008, 1'b0, 8'h00, 27'h400_0000);
      issue(32'h3F80_0000, 32'h807F_FFFF, arctan, 8'h05, 1'b0, 32'd0,
            1'b1, 1'b0, 8'h00, 27'h400_0000, 1'b1, 8'h82, 27'h3FF_FFF8);
`endif
      // signalling NaN in A
      issue(32'h7F80_0001, 32'h3F80_0000, nat_log, 8'h06, 1'b1, 32'h7FC0_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      // A = -Inf, B normal
      issue(32'hFF80_0000, 32'h4000_0000, tangent, 8'h07, 1'b1, 32'hFF80_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      // A normal, B = +Inf
      issue(32'h4049_0FDB, 32'h7F80_0000, hypotenuse, 8'h08, 1'b1, 32'h7F80_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      // two +Inf of the same sign
      issue(32'h7F80_0000, 32'h7F80_0000, PreProcess, 8'h09, 1'b1, 32'h7F80_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      // -0 and -0
      issue(32'h8000_0000, 32'h8000_0000, sinh_cosh, 8'h0A, 1'b1, 32'h8000_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      // A zero, B = -5.0
      issue(32'h0000_0000, 32'hC0A0_0000, arctanh, 8'h0B, 1'b1, 32'hC0A0_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      // A = 1.0, B = -0
      issue(32'h3F80_0000, 32'h8000_0000, exponential, 8'h0C, 1'b1, 32'h3F80_0000,
            1'b0, 1'b0, 8'h00, 27'h0, 1'b0, 8'h00, 27'h0);
      idle_cycle();
      drain();

      // back-to-back: -10.0 / 0.25, then 1.5 / 2.0, then 2.0 / 1.5
      issue(32'hC120_0000, 32'h3E80_0000, tanh_op, 8'h11, 1'b0, 32'd0,
            1'b1, 1'b1, 8'h03, 27'h500_0000, 1'b0, 8'hFE, 27'h400_0000);
      issue(32'h3FC0_0000, 32'h4000_0000, division, 8'h22, 1'b0, 32'd0,
            1'b1, 1'b0, 8'h00, 27'h600_0000, 1'b0, 8'h01, 27'h400_0000);
      issue(32'h4000_0000, 32'h3FC0_0000, nat_log, 8'h33, 1'b0, 32'd0,
            1'b1, 1'b0, 8'h01, 27'h400_0000, 1'b0, 8'h00, 27'h600_0000);
      idle_cycle();
      drain();

      // pair dropped by a reset one cycle after it is presented
      @(posedge clock);
      #1;
      valid_in = 1'b1; a_in = 32'h3FC0_0000; b_in = 32'h4000_0000;
      z_in = 32'hDEAD_BEEF; Opcode_in = division; InsTag_in = 8'h77;
      @(posedge clock);
      #1;
      valid_in = 1'b0;
      reset = 1'b1;
      @(negedge clock);
      @(negedge clock);
      check_reset_state();
      @(posedge clock);
      #1;
      reset = 1'b0;
      repeat (5) @(posedge clock);
      chk("dropped_pair_absent", q.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
